status_led_sequencer: RTL and testbench

STATUS_LED_SEQUENCER -- requirements
Module: status_led_sequencer

---
 rtl/status_led_pkg.sv | 35 +++
 rtl/led_channel_fsm.sv | 143 ++++++++++++++
 rtl/status_led_sequencer.sv | 55 +++++
 tb/tb_status_led_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/status_led_pkg.sv
// Shared types and elaboration helpers for the status LED sequencer.
package status_led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF       = 2'd0,
    MODE_ON        = 2'd1,
    MODE_HEARTBEAT = 2'd2,
    MODE_CODE      = 2'd3
  } led_mode_t;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_ON        = 3'd1,
    ST_HB_ON     = 3'd2,
    ST_HB_OFF    = 3'd3,
    ST_FLASH_ON  = 3'd4,
    ST_FLASH_OFF = 3'd5,
    ST_PAUSE     = 3'd6
  } chan_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a counter running 0..n-1 (never narrower than 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/led_channel_fsm.sv
// One LED channel: static on/off, heartbeat, or N-flash blink code with pause.
module led_channel_fsm
  import status_led_pkg::*;
#(
  parameter int unsigned CODE_W          = 4,
  parameter int unsigned FLASH_TICKS     = 2,
  parameter int unsigned PAUSE_TICKS     = 10,
  parameter int unsigned HB_ON_TICKS     = 5,
  parameter int unsigned HB_PERIOD_TICKS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [MODE_W-1:0] mode,
  input  logic [CODE_W-1:0] code,
  output logic              led,
  output logic              seq_wrap
);

  localparam int unsigned HB_OFF_TICKS = HB_PERIOD_TICKS - HB_ON_TICKS;
  localparam int unsigned MAX_PHASE    =
    max2(max2(FLASH_TICKS, PAUSE_TICKS), max2(HB_ON_TICKS, HB_OFF_TICKS));
  localparam int unsigned PH_W         = cnt_w(MAX_PHASE);

  chan_state_t       state;
  logic [MODE_W-1:0] mode_q;
  logic [PH_W-1:0]   phase_cnt;
  logic [CODE_W-1:0] flash_cnt;
  logic [CODE_W-1:0] n_q;

  logic [PH_W-1:0]   last_cnt;
  logic              mode_change;
  logic              timed;
  logic              phase_done;
  logic              last_flash;

  // Terminal phase count for the current state; phase ends on that tick.
  always_comb begin
    last_cnt = PH_W'(FLASH_TICKS - 1);
    case (state)
      ST_HB_ON:  last_cnt = PH_W'(HB_ON_TICKS - 1);
      ST_HB_OFF: last_cnt = PH_W'(HB_OFF_TICKS - 1);
      ST_PAUSE:  last_cnt = PH_W'(PAUSE_TICKS - 1);
      default:   last_cnt = PH_W'(FLASH_TICKS - 1);
    endcase
  end

  always_comb begin
    mode_change = (mode != mode_q);
    timed       = (state != ST_OFF) && (state != ST_ON);
    phase_done  = (phase_cnt == last_cnt);
    last_flash  = (flash_cnt == (n_q - CODE_W'(1)));
  end

  // A mode change wins over a coincident tick; N is latched only at sequence start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_OFF;
      mode_q    <= '0;
      phase_cnt <= '0;
      flash_cnt <= '0;
      n_q       <= '0;
      led       <= 1'b0;
      seq_wrap  <= 1'b0;
    end else begin
      mode_q   <= mode;
      seq_wrap <= 1'b0;
      if (mode_change) begin
        phase_cnt <= '0;
        flash_cnt <= '0;
        case (led_mode_t'(mode))
          MODE_OFF: begin
            state <= ST_OFF;
            led   <= 1'b0;
          end
          MODE_ON: begin
            state <= ST_ON;
            led   <= 1'b1;
          end
          MODE_HEARTBEAT: begin
            state <= ST_HB_ON;
            led   <= 1'b1;
          end
          MODE_CODE: begin
            n_q <= code;
            if (code == '0) begin
              state <= ST_PAUSE;
              led   <= 1'b0;
            end else begin
              state <= ST_FLASH_ON;
              led   <= 1'b1;
            end
          end
        endcase
      end else if (tick && timed) begin
        if (!phase_done) begin
          phase_cnt <= phase_cnt + PH_W'(1);
        end else begin
          phase_cnt <= '0;
          case (state)
            ST_HB_ON: begin
              state <= ST_HB_OFF;
              led   <= 1'b0;
            end
            ST_HB_OFF: begin
              state    <= ST_HB_ON;
              led      <= 1'b1;
              seq_wrap <= 1'b1;
            end
            ST_FLASH_ON: begin
              state <= ST_FLASH_OFF;
              led   <= 1'b0;
            end
            ST_FLASH_OFF: begin
              if (last_flash) begin
                state <= ST_PAUSE;
                led   <= 1'b0;
              end else begin
                flash_cnt <= flash_cnt + CODE_W'(1);
                state     <= ST_FLASH_ON;
                led       <= 1'b1;
              end
            end
            ST_PAUSE: begin
              seq_wrap  <= 1'b1;
              flash_cnt <= '0;
              n_q       <= code;
              if (code == '0) begin
                state <= ST_PAUSE;
                led   <= 1'b0;
              end else begin
                state <= ST_FLASH_ON;
                led   <= 1'b1;
              end
            end
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/status_led_sequencer.sv
// Shared tick prescaler driving NUM_CH independent LED channel sequencers.
module status_led_sequencer
  import status_led_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned TICK_DIV        = 5000000,
  parameter int unsigned CODE_W          = 4,
  parameter int unsigned FLASH_TICKS     = 2,
  parameter int unsigned PAUSE_TICKS     = 10,
  parameter int unsigned HB_ON_TICKS     = 5,
  parameter int unsigned HB_PERIOD_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [MODE_W*NUM_CH-1:0] mode,
  input  logic [CODE_W*NUM_CH-1:0] code,
  output logic [NUM_CH-1:0]        led,
  output logic [NUM_CH-1:0]        seq_wrap,
  output logic                     tick
);

  localparam int unsigned DIV_W = cnt_w(TICK_DIV);

  logic [DIV_W-1:0] div_cnt;

  // tick is registered one count early so it is high exactly while div_cnt == TICK_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_W'(TICK_DIV - 2));
      div_cnt <= (div_cnt == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_channel_fsm #(
      .CODE_W          (CODE_W),
      .FLASH_TICKS     (FLASH_TICKS),
      .PAUSE_TICKS     (PAUSE_TICKS),
      .HB_ON_TICKS     (HB_ON_TICKS),
      .HB_PERIOD_TICKS (HB_PERIOD_TICKS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .mode     (mode[MODE_W*i +: MODE_W]),
      .code     (code[CODE_W*i +: CODE_W]),
      .led      (led[i]),
      .seq_wrap (seq_wrap[i])
    );
  end

endmodule

// File: tb/tb_status_led_sequencer.sv
// Bench for status_led_sequencer: per-tick vector table plus hand sequences for 15-flash and reset.
module tb_status_led_sequencer;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CODE_W = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [2*NUM_CH-1:0]      mode;
  logic [CODE_W*NUM_CH-1:0] code;
  logic [NUM_CH-1:0]        led;
  logic [NUM_CH-1:0]        seq_wrap;
  logic                     tick;

  always #5 clk = ~clk;

  status_led_sequencer #(
    .NUM_CH          (NUM_CH),
    .TICK_DIV        (4),
    .CODE_W          (CODE_W),
    .FLASH_TICKS     (1),
    .PAUSE_TICKS     (3),
    .HB_ON_TICKS     (2),
    .HB_PERIOD_TICKS (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .code     (code),
    .led      (led),
    .seq_wrap (seq_wrap),
    .tick     (tick)
  );

  typedef struct {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [3:0] c0;
    logic [1:0] led;
    logic [1:0] wrap;
  } vec_t;

  typedef struct {
    logic [1:0] led;
    logic [1:0] wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] m0, input logic [1:0] m1, input logic [3:0] c0,
                     input logic [1:0] l, input logic [1:0] w);
    vec_t v;
    v.m0 = m0; v.m1 = m1; v.c0 = c0; v.led = l; v.wrap = w;
    vecs.push_back(v);
  endtask

  // Leaves time 1 unit after the clock edge on which tick was high.
  task automatic next_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   flashes;
    bit   prev;
    bit   got_wrap;
    exp_t e;

    // Idle, mode 0 on both channels.
    repeat (3) add(2'd0, 2'd0, 4'd0, 2'b00, 2'b00);
    // ch0 CODE N=3: after-tick led0 0,1,0,1,0,0,0,0,1(wrap), twice.
    for (int r = 0; r < 2; r++) begin
      add(2'd3, 2'd0, 4'd3, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b01, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b01, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd3, 2'b01, 2'b01);
    end
    // ch1 HEARTBEAT joins while ch0 keeps its code sequence.
    add(2'd3, 2'd2, 4'd3, 2'b10, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b01, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b11, 2'b10);
    add(2'd3, 2'd2, 4'd3, 2'b10, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b10, 2'b10);
    add(2'd3, 2'd2, 4'd3, 2'b11, 2'b01);
    // code 3 -> 1 during the second flash: 3 flashes finish, then 1-flash sequence.
    add(2'd3, 2'd2, 4'd3, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd3, 2'b01, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b10, 2'b10);
    add(2'd3, 2'd2, 4'd1, 2'b11, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b10, 2'b10);
    add(2'd3, 2'd2, 4'd1, 2'b10, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b01, 2'b01);
    add(2'd3, 2'd2, 4'd1, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b10, 2'b10);
    add(2'd3, 2'd2, 4'd1, 2'b10, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b00, 2'b00);
    add(2'd3, 2'd2, 4'd1, 2'b01, 2'b01);
    // Both OFF, then ch0 CODE N=0: dark, wrap every 3 ticks.
    add(2'd0, 2'd0, 4'd0, 2'b00, 2'b00);
    for (int r = 0; r < 2; r++) begin
      add(2'd3, 2'd0, 4'd0, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd0, 2'b00, 2'b00);
      add(2'd3, 2'd0, 4'd0, 2'b00, 2'b01);
    end

    reset = 1'b0;
    mode  = '0;
    code  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({tick, led, seq_wrap}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle_cycle%0d", i), 32'({tick, led, seq_wrap}),
          32'({(i % 4 == 3), 4'b0000}));
    end

    next_tick();
    foreach (vecs[i]) begin
      mode = {vecs[i].m1, vecs[i].m0};
      code = {4'd0, vecs[i].c0};
      e.led  = vecs[i].led;
      e.wrap = vecs[i].wrap;
      sb.push_back(e);
      next_tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d", i), 32'({led, seq_wrap}), 32'({e.led, e.wrap}));
    end

    // CODE with N=15: count rising edges of led0 until the sequence wraps.
    mode = 4'b0000;
    next_tick();
    chk("off_before_n15", 32'(led), 32'd0);
    mode     = 4'b0011;
    code     = 8'h0F;
    flashes  = 0;
    prev     = 1'b0;
    got_wrap = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (seq_wrap[0]) begin
        got_wrap = 1'b1;
        break;
      end
      if (led[0] && !prev) flashes++;
      prev = led[0];
    end
    chk("n15_wrap_seen", 32'(got_wrap), 32'd1);
    chk("n15_flashes", 32'(flashes), 32'd15);
    chk("flash_on_before_reset", 32'(led[0]), 32'd1);

    // Reset mid-FLASH_ON, released with ch0 = ON.
    #2;
    reset = 1'b0;
    mode  = 4'b0001;
    #1;
    chk("async_reset_outputs", 32'({tick, led, seq_wrap}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("led_in_reset%0d", i), 32'(led), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("led_after_release", 32'({led, seq_wrap}), 32'({2'b01, 2'b00}));
    next_tick();
    chk("on_holds", 32'({led, seq_wrap}), 32'({2'b01, 2'b00}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
